alarm_unit: RTL and testbench

ALARM_UNIT -- requirements
Module: alarm_unit

---
 rtl/alarm_pkg.sv | 31 +++
 rtl/alarm_bcd_counter.sv | 29 ++
 rtl/alarm_unit.sv | 185 ++++++++++++++++++
 tb/tb_alarm_unit.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm unit: state encoding, BCD limits,
// power-on alarm time and the BCD step helper.
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RINGING = 2'd2,
    ST_SNOOZE  = 2'd3
  } alarm_state_e;

  localparam logic [7:0] MIN_MAX_BCD     = 8'h59;
  localparam logic [7:0] HR_MAX_BCD      = 8'h23;
  localparam logic [7:0] RST_ALM_HR_BCD  = 8'h07;
  localparam logic [7:0] RST_ALM_MIN_BCD = 8'h00;

  // Next two-digit BCD value, wrapping to 00 after max_value.
  function automatic logic [7:0] bcd_step(input logic [7:0] value,
                                          input logic [7:0] max_value);
    logic [7:0] next_v;
    if (value == max_value) begin
      next_v = 8'h00;
    end else if (value[3:0] == 4'd9) begin
      next_v = {value[7:4] + 4'd1, 4'd0};
    end else begin
      next_v = {value[7:4], value[3:0] + 4'd1};
    end
    return next_v;
  endfunction

endpackage

// File: rtl/alarm_bcd_counter.sv
// Two-digit BCD wrap counter used for the alarm hour and minute fields.
module alarm_bcd_counter
  import alarm_pkg::*;
#(
  parameter logic [7:0] MAX_BCD = 8'h59,
  parameter logic [7:0] RST_BCD = 8'h00
) (
  input  logic       CLOCK_50,
  input  logic       RST,
  input  logic       inc,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [7:0] value_r;

  // Step the stored value on each accepted increment pulse.
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      value_r <= RST_BCD;
    end else if (inc) begin
      value_r <= bcd_step(value_r, MAX_BCD);
    end
  end

  assign tens = value_r[7:4];
  assign ones = value_r[3:0];

endmodule

// File: rtl/alarm_unit.sv
// Alarm clock controller: alarm time entry, match detection and ring/snooze FSM.
// Optional snooze behaviour is enabled by defining ALARM_SNOOZE_EN.
module alarm_unit
  import alarm_pkg::*;
#(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300
) (
  input  logic       CLOCK_50,
  input  logic       RST,
  input  logic       tick_1hz,
  input  logic [3:0] hr1,
  input  logic [3:0] hr0,
  input  logic [3:0] min1,
  input  logic [3:0] min0,
  input  logic [3:0] sec1,
  input  logic [3:0] sec0,
  input  logic       arm,
  input  logic       alm_set,
  input  logic       inc_hr,
  input  logic       inc_min,
  input  logic       stop,
  input  logic       snooze,
  output logic [3:0] alm_hr1,
  output logic [3:0] alm_hr0,
  output logic [3:0] alm_min1,
  output logic [3:0] alm_min0,
  output logic       ringing,
  output logic       led_blink,
  output logic [1:0] state
);

  localparam int CNT_MAX = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  alarm_state_e     state_r;
  logic [CNT_W-1:0] ring_cnt_r;
  logic             ringing_r;
  logic             led_blink_r;
  logic             match_s;
  logic             match_r;
  logic             alm_set_r;
  logic             trigger_s;
  logic             alm_set_rise_s;
  logic             inc_hr_s;
  logic             inc_min_s;

`ifdef ALARM_SNOOZE_EN
  logic [CNT_W-1:0] snz_cnt_r;
`else
  logic             unused_snooze_s;
  assign unused_snooze_s = snooze;
`endif

  assign inc_hr_s  = inc_hr & alm_set;
  assign inc_min_s = inc_min & alm_set;

  alarm_bcd_counter #(.MAX_BCD(HR_MAX_BCD), .RST_BCD(RST_ALM_HR_BCD)) u_hr_cnt (
    .CLOCK_50 (CLOCK_50),
    .RST      (RST),
    .inc      (inc_hr_s),
    .tens     (alm_hr1),
    .ones     (alm_hr0)
  );

  alarm_bcd_counter #(.MAX_BCD(MIN_MAX_BCD), .RST_BCD(RST_ALM_MIN_BCD)) u_min_cnt (
    .CLOCK_50 (CLOCK_50),
    .RST      (RST),
    .inc      (inc_min_s),
    .tens     (alm_min1),
    .ones     (alm_min0)
  );

  assign match_s = arm & ~alm_set
                 & ({hr1, hr0} == {alm_hr1, alm_hr0})
                 & ({min1, min0} == {alm_min1, alm_min0})
                 & (sec1 == 4'd0) & (sec0 == 4'd0);

  // Edges of match and alm_set; a trigger fires once per rising match.
  assign trigger_s      = match_s & ~match_r;
  assign alm_set_rise_s = alm_set & ~alm_set_r;

  // Delayed copies used for edge detection.
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      match_r   <= 1'b0;
      alm_set_r <= 1'b0;
    end else begin
      match_r   <= match_s;
      alm_set_r <= alm_set;
    end
  end

  // Main alarm FSM with registered ringing and blink outputs.
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      state_r     <= ST_IDLE;
      ring_cnt_r  <= '0;
      ringing_r   <= 1'b0;
      led_blink_r <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snz_cnt_r   <= '0;
`endif
    end else if (!arm) begin
      state_r     <= ST_IDLE;
      ring_cnt_r  <= '0;
      ringing_r   <= 1'b0;
      led_blink_r <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snz_cnt_r   <= '0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r <= ST_ARMED;
        end
        ST_ARMED: begin
          if (trigger_s) begin
            state_r     <= ST_RINGING;
            ring_cnt_r  <= CNT_W'(RING_SECS);
            ringing_r   <= 1'b1;
            led_blink_r <= 1'b0;
          end
        end
        ST_RINGING: begin
          if (stop || alm_set_rise_s) begin
            state_r     <= ST_ARMED;
            ring_cnt_r  <= '0;
            ringing_r   <= 1'b0;
            led_blink_r <= 1'b0;
`ifdef ALARM_SNOOZE_EN
          end else if (snooze) begin
            state_r     <= ST_SNOOZE;
            snz_cnt_r   <= CNT_W'(SNOOZE_SECS);
            ring_cnt_r  <= '0;
            ringing_r   <= 1'b0;
            led_blink_r <= 1'b0;
`endif
          end else if (tick_1hz) begin
            if (ring_cnt_r <= CNT_W'(1)) begin
              state_r     <= ST_ARMED;
              ring_cnt_r  <= '0;
              ringing_r   <= 1'b0;
              led_blink_r <= 1'b0;
            end else begin
              ring_cnt_r  <= ring_cnt_r - CNT_W'(1);
              led_blink_r <= ~led_blink_r;
            end
          end
        end
        ST_SNOOZE: begin
`ifdef ALARM_SNOOZE_EN
          if (stop || alm_set_rise_s) begin
            state_r   <= ST_ARMED;
            snz_cnt_r <= '0;
          end else if (tick_1hz) begin
            if (snz_cnt_r <= CNT_W'(1)) begin
              state_r     <= ST_RINGING;
              snz_cnt_r   <= '0;
              ring_cnt_r  <= CNT_W'(RING_SECS);
              ringing_r   <= 1'b1;
              led_blink_r <= 1'b0;
            end else begin
              snz_cnt_r <= snz_cnt_r - CNT_W'(1);
            end
          end
`else
          state_r <= ST_ARMED;
`endif
        end
        default: begin
          state_r     <= ST_IDLE;
          ring_cnt_r  <= '0;
          ringing_r   <= 1'b0;
          led_blink_r <= 1'b0;
        end
      endcase
    end
  end

  assign state     = state_r;
  assign ringing   = ringing_r;
  assign led_blink = led_blink_r;

endmodule

// File: tb/tb_alarm_unit.sv
// Directed self-checking bench for alarm_unit; covers the snooze path when
// ALARM_SNOOZE_EN is defined.
module tb_alarm_unit;

  logic       CLOCK_50 = 1'b0;
  logic       RST;
  logic       tick_1hz, arm, alm_set, inc_hr, inc_min, stop, snooze;
  logic [3:0] hr1, hr0, min1, min0, sec1, sec0;
  logic [3:0] alm_hr1, alm_hr0, alm_min1, alm_min0;
  logic       ringing, led_blink;
  logic [1:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  alarm_unit #(.RING_SECS(60), .SNOOZE_SECS(300)) dut (
    .CLOCK_50 (CLOCK_50), .RST (RST), .tick_1hz (tick_1hz),
    .hr1 (hr1), .hr0 (hr0), .min1 (min1), .min0 (min0), .sec1 (sec1), .sec0 (sec0),
    .arm (arm), .alm_set (alm_set), .inc_hr (inc_hr), .inc_min (inc_min),
    .stop (stop), .snooze (snooze),
    .alm_hr1 (alm_hr1), .alm_hr0 (alm_hr0), .alm_min1 (alm_min1), .alm_min0 (alm_min0),
    .ringing (ringing), .led_blink (led_blink), .state (state)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic check_eq(input string tag, input logic [31:0] actual,
                          input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      tick_1hz = 1'b1; step(1);
      tick_1hz = 1'b0; step(1);
    end
  endtask

  task automatic pulse_min(input int n);
    for (int i = 0; i < n; i++) begin
      inc_min = 1'b1; step(1);
      inc_min = 1'b0; step(1);
    end
  endtask

  task automatic pulse_hr(input int n);
    for (int i = 0; i < n; i++) begin
      inc_hr = 1'b1; step(1);
      inc_hr = 1'b0; step(1);
    end
  endtask

  task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    {hr1, hr0}   = h;
    {min1, min0} = m;
    {sec1, sec0} = s;
  endtask

  function automatic logic [15:0] alarm_time();
    return {alm_hr1, alm_hr0, alm_min1, alm_min0};
  endfunction

  // Leave the alarm time (first), then return to it to produce a fresh match edge.
  task automatic retrigger(input logic [7:0] h, input logic [7:0] m);
    set_time(h, m, 8'h01); step(1);
    set_time(h, m, 8'h00); step(1);
  endtask

  initial begin
    RST = 1'b1; tick_1hz = 1'b0; arm = 1'b0; alm_set = 1'b0;
    inc_hr = 1'b0; inc_min = 1'b0; stop = 1'b0; snooze = 1'b0;
    set_time(8'h07, 8'h06, 8'h59);
    #25;
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_alarm", 32'(alarm_time()), 32'h0700);
    check_eq("rst_ringing", 32'(ringing), 32'd0);
    check_eq("rst_led", 32'(led_blink), 32'd0);
    @(negedge CLOCK_50); RST = 1'b0;
    step(1);
    check_eq("idle_no_arm", 32'(state), 32'd0);
    arm = 1'b1; step(1);
    check_eq("armed", 32'(state), 32'd1);

    alm_set = 1'b1; step(1);
    pulse_min(7);
    check_eq("set_0707", 32'(alarm_time()), 32'h0707);
    alm_set = 1'b0; step(1);
    pulse_min(1); pulse_hr(1);
    check_eq("inc_ignored", 32'(alarm_time()), 32'h0707);

    set_time(8'h07, 8'h07, 8'h00); step(1);
    check_eq("trig_ringing", 32'(ringing), 32'd1);
    check_eq("trig_state", 32'(state), 32'd2);
    tick(1);
    check_eq("led_tick1", 32'(led_blink), 32'd1);
    tick(58);
    check_eq("ring_59_state", 32'(state), 32'd2);
    check_eq("led_tick59", 32'(led_blink), 32'd1);
    tick(1);
    check_eq("auto_silence_state", 32'(state), 32'd1);
    check_eq("auto_silence_ring", 32'(ringing), 32'd0);
    check_eq("auto_silence_led", 32'(led_blink), 32'd0);
    step(3);
    check_eq("no_retrig_hold", 32'(state), 32'd1);
    set_time(8'h07, 8'h07, 8'h01); step(3);
    check_eq("no_retrig_0701", 32'(state), 32'd1);

    alm_set = 1'b1; step(1);
    pulse_min(52);
    check_eq("min_59", 32'(alarm_time()), 32'h0759);
    pulse_min(1);
    check_eq("min_wrap_no_carry", 32'(alarm_time()), 32'h0700);
    pulse_min(59); pulse_hr(16);
    check_eq("set_2359", 32'(alarm_time()), 32'h2359);
    inc_hr = 1'b1; inc_min = 1'b1; step(1);
    inc_hr = 1'b0; inc_min = 1'b0; step(1);
    check_eq("dual_wrap", 32'(alarm_time()), 32'h0000);
    pulse_min(1);
    check_eq("set_0001", 32'(alarm_time()), 32'h0001);
    alm_set = 1'b0; step(1);

    set_time(8'h00, 8'h01, 8'h00); step(1);
    check_eq("ring_0001", 32'(state), 32'd2);
`ifdef ALARM_SNOOZE_EN
    snooze = 1'b1; step(1); snooze = 1'b0;
    check_eq("snooze_state", 32'(state), 32'd3);
    check_eq("snooze_quiet", 32'(ringing), 32'd0);
    tick(299);
    check_eq("snooze_299", 32'(state), 32'd3);
    tick(1);
    check_eq("rering_state", 32'(state), 32'd2);
    check_eq("rering_ringing", 32'(ringing), 32'd1);
    stop = 1'b1; snooze = 1'b1; step(1);
    stop = 1'b0; snooze = 1'b0;
    check_eq("stop_beats_snooze", 32'(state), 32'd1);
`else
    snooze = 1'b1; step(1); snooze = 1'b0;
    check_eq("snooze_ignored", 32'(state), 32'd2);
    stop = 1'b1; step(1); stop = 1'b0;
    check_eq("stop_ring", 32'(state), 32'd1);
`endif

    retrigger(8'h00, 8'h01);
    check_eq("ring_again", 32'(state), 32'd2);
    alm_set = 1'b1; step(1);
    check_eq("alm_set_dismiss", 32'(state), 32'd1);
    alm_set = 1'b0; step(1);

    retrigger(8'h00, 8'h01);
    check_eq("ring_for_disarm", 32'(state), 32'd2);
    arm = 1'b0; step(1);
    check_eq("disarm_state", 32'(state), 32'd0);
    check_eq("disarm_ringing", 32'(ringing), 32'd0);
    arm = 1'b1; step(1);
    check_eq("rearm", 32'(state), 32'd1);

    retrigger(8'h00, 8'h01);
`ifdef ALARM_SNOOZE_EN
    snooze = 1'b1; step(1); snooze = 1'b0;
    check_eq("pre_rst_snooze", 32'(state), 32'd3);
`else
    check_eq("pre_rst_ringing", 32'(state), 32'd2);
`endif
    RST = 1'b1; #2;
    check_eq("async_rst_state", 32'(state), 32'd0);
    check_eq("async_rst_alarm", 32'(alarm_time()), 32'h0700);
    check_eq("async_rst_ringing", 32'(ringing), 32'd0);
    @(negedge CLOCK_50); RST = 1'b0;
    step(1);
    check_eq("post_rst_armed", 32'(state), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
